// File: rtl/xilinx_rst_seq_pkg.sv
// Shared types and default constants for the FPGA emulation reset sequencer.
// Optional feature macro (used by xilinx_rst_sequencer): XILINX_RST_DEBOUNCE_EN
package xilinx_rst_seq_pkg;

  typedef enum logic [1:0] {
    S_RST       = 2'd0,
    S_WAIT_LOCK = 2'd1,
    S_HOLD      = 2'd2,
    S_RUN       = 2'd3
  } rst_state_e;

  localparam int DEF_SYNC_STAGES     = 2;
  localparam int DEF_HOLD_CYCLES     = 1024;
  localparam int DEF_DEBOUNCE_CYCLES = 65536;
  localparam int DEF_CNT_W           = 8;

  // Width of a counter that must be able to hold values 0..max_val.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/xilinx_cdc_sync.sv
// Multi-flop synchronizer bringing one asynchronous bit into the clk_i domain.
// Clears to 0 on rst_ni so downstream logic sees "no lock / no button" at power-up.
module xilinx_cdc_sync #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] r_sync;

  if (STAGES < 2) begin : g_bad_stages
    $error("xilinx_cdc_sync: STAGES must be at least 2");
  end

  // Shift the raw input through the synchronizer chain.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], d_i};
    end
  end

  assign q_o = r_sync[STAGES-1];

endmodule

// File: rtl/xilinx_rst_sequencer.sv
// Reset sequencer: merges board POR, reset button and MMCM lock into one clean
// active-low SoC reset that is released synchronously after a stable-lock hold time.
// Optional button debounce is enabled by defining XILINX_RST_DEBOUNCE_EN.
module xilinx_rst_sequencer
  import xilinx_rst_seq_pkg::*;
#(
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int CNT_W           = DEF_CNT_W
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             btn_rst_i,
  input  logic             mmcm_locked_i,
  output logic             soc_rst_no,
  output logic             rst_done_o,
  output logic [CNT_W-1:0] rst_cnt_o
);

  localparam int                HOLD_W    = cnt_width(HOLD_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("xilinx_rst_sequencer: SYNC_STAGES must be at least 2");
  end
  if (HOLD_CYCLES < 1) begin : g_bad_hold
    $error("xilinx_rst_sequencer: HOLD_CYCLES must be at least 1");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("xilinx_rst_sequencer: DEBOUNCE_CYCLES must be at least 1");
  end

  logic w_btn_s;
  logic w_lock_s;
  logic w_btn_db;
  logic w_go;

  xilinx_cdc_sync #(.STAGES(SYNC_STAGES)) u_btn_sync (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (btn_rst_i),
    .q_o    (w_btn_s)
  );

  xilinx_cdc_sync #(.STAGES(SYNC_STAGES)) u_lock_sync (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (mmcm_locked_i),
    .q_o    (w_lock_s)
  );

`ifdef XILINX_RST_DEBOUNCE_EN
  localparam int              DB_W    = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic [DB_W-1:0] r_db_cnt;
  logic            r_btn_db;

  // Accept a new button level only after it has persisted for DEBOUNCE_CYCLES edges.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_db_cnt <= '0;
      r_btn_db <= 1'b0;
    end else if (w_btn_s == r_btn_db) begin
      r_db_cnt <= '0;
    end else if (r_db_cnt == DB_LAST) begin
      r_db_cnt <= '0;
      r_btn_db <= w_btn_s;
    end else begin
      r_db_cnt <= r_db_cnt + 1'b1;
    end
  end

  assign w_btn_db = r_btn_db;
`else
  assign w_btn_db = w_btn_s;
`endif

  // Conditions allowing the SoC to come (or stay) out of reset.
  assign w_go = w_lock_s & ~w_btn_db;

  rst_state_e        r_state;
  logic [HOLD_W-1:0] r_hold_cnt;
  logic              r_soc_rst_n;
  logic              r_rst_done;
  logic [CNT_W-1:0]  r_rst_cnt;

  // Sequencer FSM; outputs are registered alongside the state they belong to.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= S_RST;
      r_hold_cnt  <= '0;
      r_soc_rst_n <= 1'b0;
      r_rst_done  <= 1'b0;
      r_rst_cnt   <= '0;
    end else begin
      case (r_state)
        S_RST: begin
          r_state    <= S_WAIT_LOCK;
          r_hold_cnt <= '0;
        end
        S_WAIT_LOCK: begin
          if (w_go) begin
            r_state    <= S_HOLD;
            r_hold_cnt <= '0;
          end
        end
        S_HOLD: begin
          // Any disturbance wins over completion and forces a full restart.
          if (!w_go) begin
            r_state <= S_WAIT_LOCK;
          end else if (r_hold_cnt == HOLD_LAST) begin
            r_state     <= S_RUN;
            r_soc_rst_n <= 1'b1;
            r_rst_done  <= 1'b1;
          end else begin
            r_hold_cnt <= r_hold_cnt + 1'b1;
          end
        end
        S_RUN: begin
          if (!w_go) begin
            r_state     <= S_WAIT_LOCK;
            r_soc_rst_n <= 1'b0;
            r_rst_done  <= 1'b0;
            if (r_rst_cnt != '1) begin
              r_rst_cnt <= r_rst_cnt + 1'b1;
            end
          end
        end
        default: begin
          r_state <= S_RST;
        end
      endcase
    end
  end

  assign soc_rst_no = r_soc_rst_n;
  assign rst_done_o = r_rst_done;
  assign rst_cnt_o  = r_rst_cnt;

endmodule

// File: tb/tb_xilinx_rst_sequencer.sv
// Randomized + directed bench for xilinx_rst_sequencer against a streak-based reference model.
// Honors XILINX_RST_DEBOUNCE_EN the same way as the design.
module tb_xilinx_rst_sequencer;

  localparam int SYNC  = 2;
  localparam int HOLD  = 16;
  localparam int DEB   = 8;
  localparam int CNT_W = 8;
  localparam int CMAX  = (1 << CNT_W) - 1;
  localparam int HD    = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             btn = 1'b0;
  logic             lock = 1'b0;
  logic             soc_rst_n;
  logic             rst_done;
  logic [CNT_W-1:0] rst_cnt;

  always #5 clk = ~clk;

  xilinx_rst_sequencer #(
    .SYNC_STAGES     (SYNC),
    .HOLD_CYCLES     (HOLD),
    .DEBOUNCE_CYCLES (DEB),
    .CNT_W           (CNT_W)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .btn_rst_i     (btn),
    .mmcm_locked_i (lock),
    .soc_rst_no    (soc_rst_n),
    .rst_done_o    (rst_done),
    .rst_cnt_o     (rst_cnt)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model: input history windows, a streak of "eligible" edges, event count.
  bit lock_d[HD];
  bit btn_d[HD];
  int n_edges;
  int streak;
  bit m_run;
  int m_cnt;
  bit m_db;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < HD; i++) begin
      lock_d[i] = 1'b0;
      btn_d[i]  = 1'b0;
    end
    n_edges = 0;
    streak  = 0;
    m_run   = 1'b0;
    m_cnt   = 0;
    m_db    = 1'b0;
  endtask

  // One rising edge seen with input values l/b sampled on it.
  task automatic model_edge(input bit l, input bit b);
    bit ok;
    bit new_run;
    bit all_diff;
    for (int i = HD - 1; i > 0; i--) begin
      lock_d[i] = lock_d[i-1];
      btn_d[i]  = btn_d[i-1];
    end
    lock_d[0] = l;
    btn_d[0]  = b;
    n_edges++;
`ifdef XILINX_RST_DEBOUNCE_EN
    ok = lock_d[SYNC] && !m_db;
    all_diff = 1'b1;
    for (int j = 0; j < DEB; j++) begin
      if (btn_d[SYNC+j] == m_db) all_diff = 1'b0;
    end
    if (all_diff) m_db = !m_db;
`else
    all_diff = 1'b0;
    ok = lock_d[SYNC] && !btn_d[SYNC];
`endif
    // The first edge after reset is spent leaving the reset state.
    if (n_edges == 1) streak = 0;
    else if (ok)      streak++;
    else              streak = 0;
    // Release needs the conditions on HOLD+1 consecutive edges (entry plus HOLD counts).
    new_run = (streak >= HOLD + 1);
    if (m_run && !new_run && m_cnt < CMAX) m_cnt++;
    m_run = new_run;
  endtask

  task automatic cycle(input bit l, input bit b);
    lock = l;
    btn  = b;
    @(posedge clk);
    #1;
    if (!rst_n) model_reset();
    else        model_edge(l, b);
    check_value("soc_rst_no", soc_rst_n, m_run);
    check_value("rst_done", rst_done, m_run);
    check_value("rst_cnt", rst_cnt, m_cnt);
  endtask

  task automatic settle();
    repeat (25) cycle(1'b1, 1'b0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  e;
    bit  found;
    bit  stayed;
    bit  l;
    bit  b;
    int  seg;

    model_reset();
    // Power-up: reset low for 5 cycles with lock already high.
    rst_n = 1'b0;
    repeat (5) cycle(1'b1, 1'b0);
    rst_n = 1'b1;
    e = 0; found = 1'b0;
    for (int i = 1; i <= 60; i++) begin
      cycle(1'b1, 1'b0);
      if (!found && soc_rst_n) begin e = i; found = 1'b1; end
    end
    check_value("powerup_release_edge", e, SYNC + 1 + HOLD);

    // Lock loss in RUN: soc_rst_no falls SYNC+1 edges later.
    e = 0; found = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      cycle(1'b0, 1'b0);
      if (!found && !soc_rst_n) begin e = i; found = 1'b1; end
    end
    check_value("lockloss_fall_edge", e, SYNC + 1);
    check_value("lockloss_cnt", rst_cnt, 1);

    // Lock glitch part-way through HOLD forces a full restart.
    repeat (12) cycle(1'b1, 1'b0);
    repeat (3) cycle(1'b0, 1'b0);
    e = 0; found = 1'b0;
    for (int i = 1; i <= 60; i++) begin
      cycle(1'b1, 1'b0);
      if (!found && soc_rst_n) begin e = i; found = 1'b1; end
    end
    check_value("glitch_release_edge", e, SYNC + 1 + HOLD);

    // Button behaviour.
`ifdef XILINX_RST_DEBOUNCE_EN
    stayed = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      cycle(1'b1, i <= 5);
      if (!soc_rst_n) stayed = 1'b0;
    end
    check_value("short_pulse_ignored", stayed, 1);
    e = 0; found = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      cycle(1'b1, i <= 12);
      if (!found && !soc_rst_n) begin e = i; found = 1'b1; end
    end
    check_value("press_fall_edge", e, SYNC + DEB + 1);
`else
    e = 0; found = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      cycle(1'b1, i <= 3);
      if (!found && !soc_rst_n) begin e = i; found = 1'b1; end
    end
    check_value("press_fall_edge", e, SYNC + 1);
`endif
    repeat (40) cycle(1'b1, 1'b0);

    // Repeated lock loss drives the event counter into saturation.
    repeat (300) begin
      cycle(1'b0, 1'b0);
      repeat (22) cycle(1'b1, 1'b0);
    end
    check_value("cnt_saturated", rst_cnt, CMAX);

    // Asynchronous reset in the middle of HOLD clears outputs without a clock edge.
    cycle(1'b0, 1'b0);
    repeat (10) cycle(1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_value("async_soc_rst_no", soc_rst_n, 0);
    check_value("async_rst_done", rst_done, 0);
    check_value("async_rst_cnt", rst_cnt, 0);
    model_reset();
    repeat (2) cycle(1'b1, 1'b0);
    rst_n = 1'b1;
    settle();

    // Randomized segments of lock/button activity with occasional resets.
    for (int s = 0; s < 250; s++) begin
      seg = $urandom_range(1, 40);
      l   = ($urandom_range(0, 99) < 75);
      b   = ($urandom_range(0, 99) < 15);
      if ($urandom_range(0, 99) < 3) rst_n = 1'b0;
      repeat (seg) begin
        cycle(l, b);
        rst_n = 1'b1;
      end
    end
    settle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
